// File: rtl/lcd_pkg.sv
// Shared command constants, FSM states and bus-word type for the LCD frame writer.
// Optional build macro used by lcd_frame_writer: LCD_FRAME_TE_SYNC_EN.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam int WINDOW_WORDS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_WAIT_TE,
    ST_WINDOW,
    ST_PIXEL,
    ST_DONE
  } lcd_state_e;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } lcd_word_t;

  // Word idx of the full-screen window preamble: CASET x4 args, PASET x4 args, RAMWR.
  function automatic lcd_word_t window_word(input logic [3:0] idx, input int h_res,
                                            input int v_res);
    logic [15:0] last_col;
    logic [15:0] last_row;
    lcd_word_t   w;
    last_col = 16'(h_res - 1);
    last_row = 16'(v_res - 1);
    w.rs   = 1'b1;
    w.data = 16'h0000;
    case (idx)
      4'd0:    begin w.rs = 1'b0; w.data = {8'h00, CMD_CASET}; end
      4'd3:    w.data = {8'h00, last_col[15:8]};
      4'd4:    w.data = {8'h00, last_col[7:0]};
      4'd5:    begin w.rs = 1'b0; w.data = {8'h00, CMD_PASET}; end
      4'd8:    w.data = {8'h00, last_row[15:8]};
      4'd9:    w.data = {8'h00, last_row[7:0]};
      4'd10:   begin w.rs = 1'b0; w.data = {8'h00, CMD_RAMWR}; end
      default: w.data = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Drives one 8080-style bus word at a time: holds LCD_DATA/LCD_RS and shapes the
// LCD_WR low/high phases from WR_LOW_CYC/WR_HIGH_CYC.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        word_valid,
  input  lcd_word_t   word,
  output logic        word_ready,
  output logic        idle,
  output logic        lcd_wr,
  output logic        lcd_rs,
  output logic [15:0] lcd_data
);

  localparam int MAX_CYC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             active_q, active_d;
  logic             low_q, low_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             rs_q, rs_d;
  logic [15:0]      data_q, data_d;
  logic             last_high;

  // A new word may be taken while idle or in the final high cycle of the current one.
  assign last_high  = active_q && !low_q && (cnt_q == CNT_W'(WR_HIGH_CYC - 1));
  assign word_ready = !active_q || last_high;
  assign idle       = !active_q;
  assign lcd_wr     = wr_q;
  assign lcd_rs     = rs_q;
  assign lcd_data   = data_q;

  always_comb begin
    active_d = active_q;
    low_d    = low_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rs_d     = rs_q;
    data_d   = data_q;
    if (active_q) begin
      if (low_q) begin
        if (cnt_q == CNT_W'(WR_LOW_CYC - 1)) begin
          low_d = 1'b0;
          cnt_d = '0;
          wr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (last_high) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (word_valid && word_ready) begin
      active_d = 1'b1;
      low_d    = 1'b1;
      cnt_d    = '0;
      wr_d     = 1'b0;
      rs_d     = word.rs;
      data_d   = word.data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      low_q    <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= 1'b1;
      rs_q     <= 1'b1;
      data_q   <= 16'h0000;
    end else begin
      active_q <= active_d;
      low_q    <= low_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// Per-frame LCD writer: window preamble, RAMWR, then H_RES*V_RES renderer pixels.
// Build macro LCD_FRAME_TE_SYNC_EN adds lcd_te and holds each frame until a TE rising edge.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_done,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        LCD_CS,
  output logic        LCD_RS,
  output logic        LCD_WR,
  output logic [15:0] LCD_DATA
`ifdef LCD_FRAME_TE_SYNC_EN
  ,
  input  logic        lcd_te
`endif
);

  localparam int TOTAL_PIX = H_RES * V_RES;
  localparam int PIX_W     = (TOTAL_PIX > 1) ? $clog2(TOTAL_PIX) : 1;

  lcd_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             last_acc_q, last_acc_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             word_valid, word_ready, wr_idle;
  lcd_word_t        word;

`ifdef LCD_FRAME_TE_SYNC_EN
  logic te_meta_q, te_sync_q, te_prev_q, te_rise;
  assign te_rise = te_sync_q && !te_prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      te_meta_q <= 1'b0;
      te_sync_q <= 1'b0;
      te_prev_q <= 1'b0;
    end else begin
      te_meta_q <= lcd_te;
      te_sync_q <= te_meta_q;
      te_prev_q <= te_sync_q;
    end
  end
`endif

  assign LCD_CS     = cs_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;

  // Handshakes (pix_valid/pix_ready and word_valid/word_ready): a transfer happens in a
  // cycle where both are high; valid never depends on ready, and ready may drop anytime.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pix_cnt_d  = pix_cnt_q;
    last_acc_d = last_acc_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_valid = 1'b0;
    word       = '{rs: 1'b1, data: 16'h0000};
    pix_ready  = 1'b0;
    case (state_q)
      ST_IDLE: if (init_done) state_d = ST_READY;
      ST_READY: begin
        if (frame_start) begin
          busy_d = 1'b1;
`ifdef LCD_FRAME_TE_SYNC_EN
          state_d = ST_WAIT_TE;
`else
          state_d = ST_WINDOW;
          cs_d    = 1'b0;
`endif
        end
      end
      ST_WAIT_TE: begin
`ifdef LCD_FRAME_TE_SYNC_EN
        if (te_rise) begin
          state_d = ST_WINDOW;
          cs_d    = 1'b0;
        end
`else
        state_d = ST_WINDOW;
        cs_d    = 1'b0;
`endif
      end
      ST_WINDOW: begin
        word_valid = 1'b1;
        word       = window_word(idx_q, H_RES, V_RES);
        if (word_ready) begin
          if (idx_q == 4'(WINDOW_WORDS - 1)) begin
            idx_d   = '0;
            state_d = ST_PIXEL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_PIXEL: begin
        if (!last_acc_q) begin
          pix_ready  = word_ready;
          word_valid = pix_valid;
          word       = '{rs: 1'b1, data: pix_data};
          if (pix_valid && word_ready) begin
            if (pix_cnt_q == PIX_W'(TOTAL_PIX - 1)) begin
              pix_cnt_d  = '0;
              last_acc_d = 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end
        end else if (wr_idle) begin
          // Last pixel has finished its high phase; release the panel.
          state_d = ST_DONE;
          done_d  = 1'b1;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        last_acc_d = 1'b0;
        state_d    = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pix_cnt_q  <= '0;
      last_acc_q <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pix_cnt_q  <= pix_cnt_d;
      last_acc_q <= last_acc_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  lcd_bus_writer #(
    .WR_LOW_CYC (WR_LOW_CYC),
    .WR_HIGH_CYC(WR_HIGH_CYC)
  ) u_bus (
    .clk       (clk),
    .rstn      (rstn),
    .word_valid(word_valid),
    .word      (word),
    .word_ready(word_ready),
    .idle      (wr_idle),
    .lcd_wr    (LCD_WR),
    .lcd_rs    (LCD_RS),
    .lcd_data  (LCD_DATA)
  );

endmodule
